lcd_serial_master: RTL

//  Parametrised single-clock serial master for the LCD controller bus.

---
 rtl/lcd_serial_master.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/lcd_serial_master.sv
// rtl/lcd_serial_master.sv - single-clock serial master for the LCD controller bus
// Define LCD_SERIAL_PARITY_EN to append an even-parity bit after the data field.
module lcd_serial_master #(
  parameter int ADDR_WIDTH    = 7,
  parameter int DATA_WIDTH    = 8,
  parameter int CLKS_PER_HALF = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_txData,
  input  logic                  i_rxSerial,
  output logic                  o_clock,
  output logic                  o_serialEnable,
  output logic                  o_txSerial,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rxData
`ifdef LCD_SERIAL_PARITY_EN
  ,
  output logic                  o_parityError
`endif
);
  localparam int MAX_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int BIT_W = $clog2(MAX_WIDTH + 1);
  localparam int DIV_W = (CLKS_PER_HALF > 1) ? $clog2(CLKS_PER_HALF) : 1;
  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_WIDTH - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_HALF - 1);

  typedef enum logic [2:0] {
    IDLE, LEAD, START, ADDR, DATA,
`ifdef LCD_SERIAL_PARITY_EN
    PARITY,
`endif
    LAG
  } stateType;

  stateType              state, nextState;
  logic [DIV_W-1:0]      divCount;
  logic                  halfHigh;
  logic [BIT_W-1:0]      bitCount;
  logic                  isRead;
  logic [ADDR_WIDTH-1:0] addrShift;
  logic [DATA_WIDTH-1:0] dataShift;
  logic                  bitEnd;
  logic                  shifting;
`ifdef LCD_SERIAL_PARITY_EN
  logic                  txParity;
  logic                  rxParityBad;
`endif

  // A bit ends on the last system clock of its high half.
  assign bitEnd = halfHigh && (divCount == DIV_LAST);

  always_comb begin
    nextState      = state;
    shifting       = 1'b0;
    o_txSerial     = 1'b0;
    o_busy         = (state != IDLE);
    o_serialEnable = (state == IDLE);
    case (state)
      IDLE:  if (i_start) nextState = LEAD;
      LEAD:  if (bitEnd) nextState = START;
      START: begin
        shifting   = 1'b1;
        o_txSerial = isRead;
        if (bitEnd) nextState = ADDR;
      end
      ADDR: begin
        shifting   = 1'b1;
        o_txSerial = addrShift[ADDR_WIDTH-1];
        if (bitEnd && bitCount == '0) nextState = DATA;
      end
      DATA: begin
        shifting   = 1'b1;
        o_txSerial = !isRead && dataShift[DATA_WIDTH-1];
`ifdef LCD_SERIAL_PARITY_EN
        if (bitEnd && bitCount == '0) nextState = PARITY;
      end
      PARITY: begin
        shifting   = 1'b1;
        o_txSerial = !isRead && txParity;
        if (bitEnd) nextState = LAG;
`else
        if (bitEnd && bitCount == '0) nextState = LAG;
`endif
      end
      LAG:     if (bitEnd) nextState = IDLE;
      default: nextState = IDLE;
    endcase
    o_clock = shifting && halfHigh;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      divCount    <= '0;
      halfHigh    <= 1'b0;
      bitCount    <= '0;
      isRead      <= 1'b0;
      addrShift   <= '0;
      dataShift   <= '0;
      o_done      <= 1'b0;
      o_rxData    <= '0;
`ifdef LCD_SERIAL_PARITY_EN
      txParity      <= 1'b0;
      rxParityBad   <= 1'b0;
      o_parityError <= 1'b0;
`endif
    end else begin
      state  <= nextState;
      o_done <= 1'b0;
      if (state == IDLE) begin
        // Divider parked so every frame starts phase-aligned.
        divCount <= '0;
        halfHigh <= 1'b0;
        if (i_start) begin
          isRead    <= i_read;
          addrShift <= i_address;
          dataShift <= i_txData;
`ifdef LCD_SERIAL_PARITY_EN
          txParity  <= ^i_txData;
`endif
        end
      end else begin
        if (divCount == DIV_LAST) begin
          divCount <= '0;
          halfHigh <= ~halfHigh;
        end else begin
          divCount <= divCount + DIV_W'(1);
        end
        if (bitEnd) begin
          case (state)
            START: bitCount <= ADDR_LAST;
            ADDR: begin
              addrShift <= addrShift << 1;
              bitCount  <= (bitCount == '0) ? DATA_LAST : bitCount - BIT_W'(1);
            end
            DATA: begin
              // Write data shifts out; read data shifts in from the same register.
              dataShift <= DATA_WIDTH'({dataShift, isRead && i_rxSerial});
              if (bitCount != '0) bitCount <= bitCount - BIT_W'(1);
            end
`ifdef LCD_SERIAL_PARITY_EN
            PARITY: rxParityBad <= (^dataShift) ^ i_rxSerial;
`endif
            LAG: begin
              o_done <= 1'b1;
              if (isRead) begin
                o_rxData <= dataShift;
`ifdef LCD_SERIAL_PARITY_EN
                o_parityError <= rxParityBad;
`endif
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule
